// File: rtl/bus_read_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : bus_rd_pkg
// Brief    : Shared types and widths for the bus read sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package bus_rd_pkg;

  // Sequencer states: IDLE waits for a request, SELECT lets the bus settle,
  // SAMPLE captures the word, GAP is the turnaround between burst words.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Register index width (up to 16 registers on the bus).
  localparam int ADDR_W = 4;

  // Width of the settle counter (SettleCycles up to 15).
  localparam int SETTLE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/bus_read_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : bus_read_sequencer_if
// Brief    : Request / tristate-bus / read-result bundle of the sequencer.
//            burst_len exists only when BURST_READ_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface bus_read_sequencer_if
  import bus_rd_pkg::*;
#(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4
);

  logic                req;
  logic [ADDR_W-1:0]   addr;
`ifdef BURST_READ_EN
  logic [ADDR_W-1:0]   burst_len;
`endif
  logic [NrOfBits-1:0] bus_in;
  logic [NrOfRegs-1:0] cs;
  logic                busy;
  logic                rd_valid;
  logic [NrOfBits-1:0] rd_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic                err;

  // Host side: issues requests and owns the register bank driving the bus.
  modport master (
    output req,
    output addr,
`ifdef BURST_READ_EN
    output burst_len,
`endif
    output bus_in,
    input  cs,
    input  busy,
    input  rd_valid,
    input  rd_data,
    input  rd_addr,
    input  err
  );

  // Sequencer side.
  modport slave (
    input  req,
    input  addr,
`ifdef BURST_READ_EN
    input  burst_len,
`endif
    input  bus_in,
    output cs,
    output busy,
    output rd_valid,
    output rd_data,
    output rd_addr,
    output err
  );

endinterface

`default_nettype wire

// File: rtl/bus_read_sequencer_cs_decode.sv
//------------------------------------------------------------------------------
// Module   : cs_decode
// Brief    : One-cold output-disable decoder. With en_i low every register is
//            high-Z; with en_i high only register cur_i drives the bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cs_decode
  import bus_rd_pkg::*;
#(
  parameter int NrOfRegs = 4
) (
  input  logic [ADDR_W-1:0]   cur_i,
  input  logic                en_i,
  output logic [NrOfRegs-1:0] cs_o
);

  // One comparator per register; at most one bit can match cur_i.
  for (genvar i = 0; i < NrOfRegs; i++) begin : g_cs
    assign cs_o[i] = ~(en_i && (cur_i == ADDR_W'(i)));
  end

endmodule

`default_nettype wire

// File: rtl/bus_read_sequencer.sv
//------------------------------------------------------------------------------
// Module   : bus_read_sequencer
// Brief    : Reads registers sharing a tristate bus: selects one register,
//            waits SettleCycles Ticks, samples the bus, reports the word.
//            Define BURST_READ_EN to enable multi-word bursts (burst_len).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bus_read_sequencer
  import bus_rd_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int SettleCycles = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  bus_read_sequencer_if.slave  bus
);

  localparam logic [ADDR_W:0]         NR_REGS_EXT = NrOfRegs[ADDR_W:0];
  localparam logic [ADDR_W-1:0]       LAST_REG    = ADDR_W'(NrOfRegs - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SettleCycles - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cur_q, cur_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic [NrOfBits-1:0]     rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
`ifdef BURST_READ_EN
  logic [ADDR_W-1:0]       remain_q, remain_d;
`endif

  logic                    addr_ok;
  logic                    cs_en;
  logic [NrOfRegs-1:0]     cs_vec;

  assign addr_ok = ({1'b0, bus.addr} < NR_REGS_EXT);

  // Register bank state; reset clears everything so cs releases immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      settle_q   <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
`ifdef BURST_READ_EN
      remain_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      settle_q   <= settle_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
`ifdef BURST_READ_EN
      remain_q   <= remain_d;
`endif
    end
  end

  // Next-state logic; nothing advances without Tick, pulses always drop.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    settle_d   = settle_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
`ifdef BURST_READ_EN
    remain_d   = remain_q;
`endif

    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            if (addr_ok) begin
              cur_d    = bus.addr;
              settle_d = '0;
`ifdef BURST_READ_EN
              remain_d = bus.burst_len;
`endif
              state_d  = ST_SELECT;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        ST_SELECT: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = ST_SAMPLE;
          end else begin
            settle_d = settle_q + SETTLE_CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus.bus_in;
          rd_addr_d  = cur_q;
          state_d    = ST_IDLE;
`ifdef BURST_READ_EN
          // A burst running past the last register ends here with err.
          if (remain_q != '0) begin
            if (cur_q == LAST_REG) begin
              err_d = 1'b1;
            end else begin
              remain_d = remain_q - ADDR_W'(1);
              state_d  = ST_GAP;
            end
          end
`endif
        end

        ST_GAP: begin
          cur_d   = cur_q + ADDR_W'(1);
          state_d = ST_SELECT;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // cs is decoded from registered state only, so reset frees the bus at once.
  assign cs_en = (state_q == ST_SELECT) || (state_q == ST_SAMPLE);

  cs_decode #(
    .NrOfRegs (NrOfRegs)
  ) u_cs_decode (
    .cur_i (cur_q),
    .en_i  (cs_en),
    .cs_o  (cs_vec)
  );

  assign bus.cs       = cs_vec;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_read_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_read_sequencer
// Brief    : Self-checking bench for bus_read_sequencer (scoreboard based).
//            Burst scenarios are included when BURST_READ_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bus_read_sequencer;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int SC = 2;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         is_rd;
    bit         err;
    int         due;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tick = 1'b1;

  int   checks   = 0;
  int   errors   = 0;
  int   tick_cnt = 0;
  bit   last_tick = 1'b0;
  int   period   = 1;
  int   cyc      = 0;
  int   cs_low_cnt = 0;

  logic [7:0] reg_val [NR];
  logic [7:0] held_data = '0;
  logic [3:0] held_addr = '0;
  exp_t       expq [$];
  exp_t       e;

  always #5 clk = ~clk;

  bus_read_sequencer_if #(.NrOfBits(NB), .NrOfRegs(NR)) bif ();

  bus_read_sequencer #(
    .NrOfBits     (NB),
    .NrOfRegs     (NR),
    .SettleCycles (SC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .bus    (bif)
  );

  // Register bank on the tristate bus; floating bus reads as zero.
  always_comb begin
    bif.bus_in = '0;
    for (int i = 0; i < NR; i++)
      if (!bif.cs[i]) bif.bus_in = reg_val[i];
  end

  // Tick generator and tick-edge bookkeeping.
  always @(posedge clk) begin
    last_tick = tick;
    if (tick) tick_cnt++;
    #1;
    cyc++;
    tick = (period == 1) || ((cyc % period) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: bus-safety invariants and scoreboard pops on every pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.cs != '1) cs_low_cnt++;
      chk("cs_onecold", 32'($countones(~bif.cs) <= 1), 32'd1);
      if (!bif.busy) chk("cs_idle", 32'(bif.cs), 32'hF);
      if (bif.rd_valid || bif.err) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bif.rd_valid, bif.err}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("pulse_tick", last_tick ? 32'(tick_cnt - 1) : 32'hFFFF_FFFF, 32'(e.due));
          chk("rd_valid", 32'(bif.rd_valid), 32'(e.is_rd));
          chk("err", 32'(bif.err), 32'(e.err));
          if (e.is_rd) begin
            held_data = e.data;
            held_addr = e.addr;
          end
        end
      end
      chk("rd_data_hold", 32'(bif.rd_data), 32'(held_data));
      chk("rd_addr_hold", 32'(bif.rd_addr), 32'(held_addr));
    end
  end

  // Issue one request and push the responses the rules predict.
  task automatic do_req(input logic [3:0] a, input logic [3:0] bl);
    int acc;
    int n;
    int nwords;
    int g;
    cs_low_cnt = 0;
    bif.req  = 1'b1;
    bif.addr = a;
`ifdef BURST_READ_EN
    bif.burst_len = bl;
    n = int'(bl) + 1;
`else
    n = 1;
`endif
    g = 0;
    do begin @(posedge clk); g++; end while (!tick && g < 20);
    #1;
    if (g >= 20) chk("accept_timeout", 32'd1, 32'd0);
    acc = tick_cnt - 1;
    nwords = 0;
    if (int'(a) >= NR) begin
      expq.push_back('{addr: 4'd0, data: 8'd0, is_rd: 1'b0, err: 1'b1, due: acc});
      bif.req = 1'b0;
    end else begin
      for (int k = 0; k < n; k++) begin
        int  ad;
        bit  trunc;
        ad    = int'(a) + k;
        trunc = (k < n - 1) && (ad == NR - 1);
        expq.push_back('{addr: 4'(ad), data: reg_val[ad], is_rd: 1'b1, err: trunc,
                         due: acc + k * (SC + 2) + SC + 1});
        nwords++;
        if (trunc) break;
      end
      // Keep requesting with a different address; must be ignored.
      bif.addr = 4'($urandom);
      g = 0;
      do begin @(posedge clk); g++; end while (!tick && g < 20);
      #1;
      bif.req = 1'b0;
    end
    g = 0;
    do begin @(posedge clk); g++; end while (bif.busy && g < 500);
    if (g >= 500) chk("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("cs_low_clocks", 32'(cs_low_cnt), 32'(nwords * (SC + 1) * period));
  endtask

  task automatic fill_regs();
    for (int i = 0; i < NR; i++) reg_val[i] = 8'(($urandom & 32'hF0) | 32'(i));
  endtask

  initial begin
    int g;
    bif.req  = 1'b0;
    bif.addr = '0;
`ifdef BURST_READ_EN
    bif.burst_len = '0;
`endif
    fill_regs();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(bif.cs), 32'hF);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_rd_data", 32'(bif.rd_data), 32'd0);
    chk("rst_rd_addr", 32'(bif.rd_addr), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single read of register 2.
    reg_val[2] = 8'hA5;
    do_req(4'd2, 4'd0);
    // Out-of-range address.
    do_req(4'd5, 4'd0);
    // Sparse Tick.
    period = 3;
    repeat (3) @(posedge clk); #1;
    do_req(4'd1, 4'd0);
    period = 1;
    repeat (2) @(posedge clk); #1;

    // Reset during SELECT of register 3 discards the read.
    bif.req = 1'b1; bif.addr = 4'd3;
    g = 0;
    do begin @(posedge clk); g++; end while (!tick && g < 20);
    #1; bif.req = 1'b0;
    @(posedge clk); #1;
    chk("select_cs", 32'(bif.cs), 32'h7);
    #2; rst = 1'b1; #1;
    chk("midrst_cs", 32'(bif.cs), 32'hF);
    chk("midrst_busy", 32'(bif.busy), 32'd0);
    chk("midrst_valid", 32'(bif.rd_valid), 32'd0);
    held_data = '0; held_addr = '0;
    repeat (2) @(posedge clk); #1;
    chk("midrst_rd_data", 32'(bif.rd_data), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;

`ifdef BURST_READ_EN
    reg_val[1] = 8'h11; reg_val[2] = 8'h22;
    do_req(4'd1, 4'd1);
    do_req(4'd2, 4'd5);
`endif

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      logic [3:0] a;
      logic [3:0] bl;
      period = $urandom_range(1, 3);
      repeat (3) @(posedge clk); #1;
      fill_regs();
      a  = 4'($urandom_range(0, 7));
      bl = 4'($urandom_range(0, 5));
      do_req(a, bl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bus_read_sequencer.md
BUS_READ_SEQUENCER -- requirements
Module: bus_read_sequencer

Interface
REQ-001 Parameter NrOfBits, default 8, SHALL set the shared data bus width.
REQ-002 Parameter NrOfRegs, default 4, range 2..16, SHALL set the number of tristate registers on the bus.
REQ-003 Parameter SettleCycles, default 1, range 1..15, SHALL set the Tick count between select and sample.
REQ-004 Clock  input  1  single system clock, rising edge active.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Tick  input  1  global clock-enable; all state changes SHALL occur only on Clock edges with Tick=1.
REQ-007 req  input  1  read request, level-sampled in IDLE.
REQ-008 addr  input  4  index of register to read.
REQ-009 burst_len  input  4  extra consecutive registers to read (present only with BURST_READ_EN).
REQ-010 bus_in  input  NrOfBits  shared tristate bus.
REQ-011 cs  output  NrOfRegs  per-register output disable; 1 = register high-Z, 0 = register drives bus.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 rd_valid  output  1  one-Clock pulse, rd_data/rd_addr valid.
REQ-014 rd_data  output  NrOfBits  captured bus value.
REQ-015 rd_addr  output  4  index of captured register.
REQ-016 err  output  1  one-Clock pulse on out-of-range addr.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, SAMPLE, GAP.
REQ-018 IDLE: all cs=1; on Tick with req=1 and addr<NrOfRegs, latch addr, go SELECT.
REQ-019 IDLE with req=1 and addr>=NrOfRegs SHALL pulse err for one Clock, assert no cs, remain IDLE.
REQ-020 SELECT: cs[cur]=0, all other cs=1; after SettleCycles Ticks go SAMPLE.
REQ-021 SAMPLE: cs[cur] held 0; capture bus_in into rd_data, cur into rd_addr, pulse rd_valid for exactly one Clock; then IDLE, or GAP if burst words remain.
REQ-022 GAP: all cs=1 for one Tick (bus turnaround), increment cur, go SELECT.
REQ-023 At most one cs bit SHALL be 0 at any time; no cs=0 in IDLE or GAP.
REQ-024 Single-read latency: rd_valid SHALL assert SettleCycles+1 Ticks after the accepting Tick.
REQ-025 rd_data/rd_addr SHALL hold their value until the next capture.
REQ-026 req changes after acceptance SHALL be ignored until return to IDLE.
REQ-027 Tick=0 SHALL freeze state, counters and cs; rd_valid/err SHALL still deassert after one Clock.

Reset
REQ-028 Reset=1 SHALL asynchronously force: state IDLE, cs all 1, busy 0, rd_valid 0, err 0, rd_data 0, rd_addr 0, counters 0.
REQ-029 Reset mid-read SHALL release cs within the same cycle and discard the pending read.

Configuration
REQ-030 With BURST_READ_EN defined, burst_len SHALL be latched in IDLE and burst_len+1 words read at addr, addr+1, ...; a burst crossing NrOfRegs-1 SHALL stop after NrOfRegs-1 and pulse err with the last rd_valid.
REQ-031 Without BURST_READ_EN, port burst_len SHALL be absent, GAP unreachable, every request a single read.

Structure
REQ-032 Package bus_rd_pkg SHALL hold the state enum, the 4-bit address width constant and the SettleCycles counter width.
REQ-033 Sub-module cs_decode SHALL generate the one-cold cs vector from cur and an enable.

Verification
REQ-034 Reset, NrOfRegs=4, Tick=1, req addr=2, reg2 drives 0xA5 -> cs=1011 for 2 Clocks, rd_valid once, rd_data=0xA5, rd_addr=2.
REQ-035 req addr=5 -> err one Clock, cs=1111 throughout, busy 0.
REQ-036 Tick high every 3rd Clock, req addr=1 -> rd_valid after 2 Ticks (6 Clocks), cs=1101 stable between Ticks.
REQ-037 Reset asserted during SELECT addr=3 -> cs=1111 same cycle, no rd_valid afterwards.
REQ-038 BURST_READ_EN, addr=1 burst_len=1, reg1=0x11 reg2=0x22 -> rd_data 0x11 then 0x22, one all-ones cs Tick between.
REQ-039 BURST_READ_EN, addr=2 burst_len=5 -> rd_addr 2,3 then err with final rd_valid, FSM IDLE.
